// File: rtl/rr_req_arb8_if.sv
// Handshake bundle between the round-robin arbiter and its
// requesters/consumer (encoder side sees grant/valid).
interface rr_req_arb8_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       valid;
    logic [7:0] pending;

    modport master (
        output en, req, done,
        input  grant, valid, pending
    );

    modport slave (
        input  en, req, done,
        output grant, valid, pending
    );
endinterface

// File: rtl/rr_req_arb8.sv
// Eight-line round-robin arbiter with a held one-hot grant,
// feeding an 8-to-3 encoder; level or rising-edge request capture.
module rr_req_arb8 #(
    parameter int N    = 8,
    parameter bit EDGE = 1'b0
) (
    input logic         clk,
    input logic         rst,
    rr_req_arb8_if.slave bus
);
    localparam int W = $clog2(N);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;
    logic [N-1:0] pend_q,  pend_d;
    logic [N-1:0] req_q;
    logic [W-1:0] last_q,  last_d;
    logic [W-1:0] gidx_q,  gidx_d;

    logic [N-1:0] r;
    logic [N-1:0] clr;
    logic [W-1:0] win;
    logic [W-1:0] cand;
    logic         hit;
    logic         accept;

    // In level mode pend_q is just req delayed one cycle, for status only.
    assign r      = EDGE ? pend_q : bus.req;
    assign accept = (state_q == S_GRANT) && bus.en && bus.done;
    assign clr    = accept ? grant_q : '0;
    assign pend_d = EDGE ? ((pend_q & ~clr) | (bus.req & ~req_q))
                         : bus.req;

    always_comb begin
        win  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = last_q + W'(k);
            if (!hit && r[cand]) begin
                win = cand;
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en && hit) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win;
                    valid_d = 1'b1;
                    gidx_d  = win;
                    state_d = S_GRANT;
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            S_GRANT: begin
                // Abort via en wins over done and leaves fairness state alone.
                if (!bus.en) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.done) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    last_d  = gidx_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            req_q   <= '0;
            last_q  <= W'(N - 1);
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            req_q   <= bus.req;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pend_q;
endmodule

// File: tb/tb_rr_req_arb8.sv
// Scoreboard bench: level-mode and edge-mode arbiters driven in
// lock-step against a cycle model of the arbitration rules.
module tb_rr_req_arb8;
    logic clk;
    logic rst;

    rr_req_arb8_if a0 ();
    rr_req_arb8_if a1 ();

    rr_req_arb8 #(.N(8), .EDGE(1'b0)) u_lvl (
        .clk (clk),
        .rst (rst),
        .bus (a0)
    );

    rr_req_arb8 #(.N(8), .EDGE(1'b1)) u_edg (
        .clk (clk),
        .rst (rst),
        .bus (a1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] g0;
        logic       v0;
        logic [7:0] p0;
        logic [7:0] g1;
        logic       v1;
        logic [7:0] p1;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] m_grant [2];
    logic [7:0] m_pend  [2];
    logic [7:0] m_reqq  [2];
    int         m_last  [2];
    int         m_gidx  [2];
    bit         m_busy  [2];

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            m_grant[e] = '0;
            m_pend[e]  = '0;
            m_reqq[e]  = '0;
            m_last[e]  = 7;
            m_gidx[e]  = 0;
            m_busy[e]  = 1'b0;
        end
        sb.delete();
    endtask

    task automatic model_step(input int e, input bit en,
                              input logic [7:0] rq, input bit dn);
        logic [7:0] r;
        logic [7:0] clr;
        logic [7:0] ng;
        int w;
        r   = (e == 1) ? m_pend[e] : rq;
        clr = '0;
        ng  = m_grant[e];
        if (!m_busy[e]) begin
            ng = '0;
            if (en) begin
                w = -1;
                for (int k = 1; k <= 8 && w < 0; k++)
                    if (r[(m_last[e] + k) % 8]) w = (m_last[e] + k) % 8;
                if (w >= 0) begin
                    ng = 8'd1 << w;
                    m_gidx[e] = w;
                    m_busy[e] = 1'b1;
                end
            end
        end else if (!en) begin
            ng = '0;
            m_busy[e] = 1'b0;
        end else if (dn) begin
            m_last[e] = m_gidx[e];
            clr = m_grant[e];
            ng = '0;
            m_busy[e] = 1'b0;
        end
        if (e == 1) m_pend[e] = (m_pend[e] & ~clr) | (rq & ~m_reqq[e]);
        else        m_pend[e] = rq;
        m_reqq[e]  = rq;
        m_grant[e] = ng;
    endtask

    task automatic step(input bit en, input logic [7:0] rq, input bit dn);
        exp_t x;
        a0.en = en; a0.req = rq; a0.done = dn;
        a1.en = en; a1.req = rq; a1.done = dn;
        model_step(0, en, rq, dn);
        model_step(1, en, rq, dn);
        x.g0 = m_grant[0]; x.v0 = (m_grant[0] != 0); x.p0 = m_pend[0];
        x.g1 = m_grant[1]; x.v1 = (m_grant[1] != 0); x.p1 = m_pend[1];
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("lvl_grant",   a0.grant,   x.g0);
        chk("lvl_valid",   8'(a0.valid), 8'(x.v0));
        chk("lvl_pending", a0.pending, x.p0);
        chk("edg_grant",   a1.grant,   x.g1);
        chk("edg_valid",   8'(a1.valid), 8'(x.v1));
        chk("edg_pending", a1.pending, x.p1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a0.en = 0; a0.req = '0; a0.done = 0;
        a1.en = 0; a1.req = '0; a1.done = 0;
        #1;
        chk("rst_lvl_grant",   a0.grant,     8'h00);
        chk("rst_lvl_valid",   8'(a0.valid), 8'h00);
        chk("rst_lvl_pending", a0.pending,   8'h00);
        chk("rst_edg_grant",   a1.grant,     8'h00);
        chk("rst_edg_valid",   8'(a1.valid), 8'h00);
        chk("rst_edg_pending", a1.pending,   8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a0.en = 0; a0.req = '0; a0.done = 0;
        a1.en = 0; a1.req = '0; a1.done = 0;
        #2;
        do_reset();

        // Two requesters, done while each grant is visible.
        for (int i = 0; i < 8; i++) step(1'b1, 8'h24, m_grant[0] != 0);

        // Full load: rotation 01..80 and wrap back to 01.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'hFF, m_grant[0] != 0);

        // Single pulse on line 3, grant held without done.
        do_reset();
        step(1'b1, 8'h08, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);

        // New rising edge on line 3 in the same cycle as done.
        do_reset();
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h08, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0);

        // Abort by en with done high keeps last; regrant same line.
        do_reset();
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h30, 1'b0);
        step(1'b0, 8'h30, 1'b1);
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h30, 1'b1);
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h30, 1'b1);
        step(1'b1, 8'h30, 1'b0);

        // Done in IDLE is ignored; req drop in GRANT keeps grant.
        do_reset();
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h40, 1'b1);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a held grant.
        do_reset();
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        #2;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'h81, m_grant[1] != 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) != 0, 8'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
